// File: rtl/winograd_pkg.sv
// -----------------------------------------------------------------------------
// winograd_pkg
// Shared constants and types for the Winograd F(4,3) transform blocks.
//   TILE_IN  : edge length of the transformed-domain tile (6)
//   TILE_OUT : edge length of the spatial output tile (4)
//   ot_state_t : output-transform FSM states
//
// A^T (output transform), rows applied to a 6-element column/row vector:
//   [1, 1,  1, 1,  1, 0]
//   [0, 1, -1, 2, -2, 0]
//   [0, 1,  1, 4,  4, 0]
//   [0, 1, -1, 8, -8, 1]
// The 2/4/8 coefficients are realised as left shifts; AT_SH_R* hold them.
//
// B^T (input transform, same tile size), kept here for reference:
//   [4,  0, -5,  0, 1, 0]
//   [0, -4, -4,  1, 1, 0]
//   [0,  4, -4, -1, 1, 0]
//   [0, -2, -1,  2, 1, 0]
//   [0,  2, -1, -2, 1, 0]
//   [0,  4,  0, -5, 0, 1]
// -----------------------------------------------------------------------------
package winograd_pkg;

    localparam int TILE_IN  = 32'sd6;
    localparam int TILE_OUT = 32'sd4;

    // Shift amounts for the power-of-two A^T coefficients (2, 4, 8).
    localparam int AT_SH_R1 = 32'sd1;
    localparam int AT_SH_R2 = 32'sd2;
    localparam int AT_SH_R3 = 32'sd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC_T = 2'd1,
        S_CALC_Y = 2'd2,
        S_DONE   = 2'd3
    } ot_state_t;

endpackage

// File: rtl/winograd_at_kernel.sv
// -----------------------------------------------------------------------------
// winograd_at_kernel
// Combinational A^T kernel: y = A^T * x for one 6-element signed vector.
// Shift/add only. Widths are not extended; the caller sizes ACC_W so that
// the worst-case row gain (19) cannot overflow.
//   x [TILE_IN]  : signed ACC_W inputs
//   y [TILE_OUT] : signed ACC_W outputs
// -----------------------------------------------------------------------------
module winograd_at_kernel
    import winograd_pkg::*;
#(
    parameter int ACC_W = 32'sd42
) (
    input  logic signed [ACC_W-1:0] x [TILE_IN],
    output logic signed [ACC_W-1:0] y [TILE_OUT]
);

    logic signed [ACC_W-1:0] s12_s;
    logic signed [ACC_W-1:0] d12_s;
    logic signed [ACC_W-1:0] s34_s;
    logic signed [ACC_W-1:0] d34_s;

    // Pair sums/differences shared by all four A^T rows, then the rows.
    always_comb begin
        s12_s = x[1] + x[2];
        d12_s = x[1] - x[2];
        s34_s = x[3] + x[4];
        d34_s = x[3] - x[4];
        y[0]  = x[0] + s12_s + s34_s;
        y[1]  = d12_s + (d34_s <<< AT_SH_R1);
        y[2]  = s12_s + (s34_s <<< AT_SH_R2);
        y[3]  = d12_s + (d34_s <<< AT_SH_R3) + x[5];
    end

endmodule

// File: rtl/winograd_output_transform.sv
// -----------------------------------------------------------------------------
// winograd_output_transform
// Winograd F(4,3) output transform Y = A^T * M * A on a 6x6 tile.
// One cycle computes T = A^T * M (six column kernels); then four cycles emit
// one Y row each (T row through one kernel). Result held until out_ready.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input tile handshake (in_ready only in S_IDLE)
//   tile_in [6][6]      : signed IN_W M tile, [row][col]
//   out_valid/out_ready : output tile handshake
//   tile_out [4][4]     : signed OUT_W Y tile, [row][col]
//   sat_flag            : (WINOGRAD_OT_SAT_EN only) sticky clamp indicator
//   busy                : high in any state other than S_IDLE
//
// Build option: define WINOGRAD_OT_SAT_EN to saturate Y to OUT_W instead of
// wrapping, and to expose sat_flag.
// -----------------------------------------------------------------------------
module winograd_output_transform
    import winograd_pkg::*;
#(
    parameter int IN_W  = 32'sd32,
    parameter int OUT_W = 32'sd16,
    parameter int ACC_W = IN_W + 32'sd10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  tile_in  [TILE_IN][TILE_IN],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] tile_out [TILE_OUT][TILE_OUT],
`ifdef WINOGRAD_OT_SAT_EN
    output logic                    sat_flag,
`endif
    output logic                    busy
);

    ot_state_t               state_r;
    ot_state_t               state_next_s;
    logic [1:0]              row_cnt_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic                    accept_s;
    logic signed [IN_W-1:0]  m_r      [TILE_IN][TILE_IN];
    logic signed [ACC_W-1:0] t_r      [TILE_OUT][TILE_IN];
    logic signed [ACC_W-1:0] t_s      [TILE_OUT][TILE_IN];
    logic signed [ACC_W-1:0] y_in_s   [TILE_IN];
    logic signed [ACC_W-1:0] y_row_s  [TILE_OUT];
    logic signed [OUT_W-1:0] tile_out_r [TILE_OUT][TILE_OUT];

`ifdef WINOGRAD_OT_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic sat_r;
    logic sat_hit_s;

    function automatic logic is_clamp(input logic signed [ACC_W-1:0] v);
        return (v > Y_MAX) || (v < Y_MIN);
    endfunction

    function automatic logic signed [OUT_W-1:0] conv_y(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        if (v > Y_MAX) begin
            c = Y_MAX;
        end else if (v < Y_MIN) begin
            c = Y_MIN;
        end else begin
            c = v;
        end
        return c[OUT_W-1:0];
    endfunction

    // Any element of the row currently being written clamps.
    always_comb begin
        sat_hit_s = 1'b0;
        for (int j = 0; j < TILE_OUT; j++) begin
            sat_hit_s = sat_hit_s | is_clamp(y_row_s[j]);
        end
    end

    assign sat_flag = sat_r;
`else
    function automatic logic signed [OUT_W-1:0] conv_y(input logic signed [ACC_W-1:0] v);
        return v[OUT_W-1:0];
    endfunction
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign tile_out  = tile_out_r;

    // in_ready_r is only ever high in S_IDLE, so it alone qualifies acceptance.
    assign accept_s = in_valid && in_ready_r;

    // Column pass: T[:, c] = A^T * M[:, c], M sign-extended to ACC_W.
    for (genvar c = 0; c < TILE_IN; c++) begin : g_col
        logic signed [ACC_W-1:0] col_s  [TILE_IN];
        logic signed [ACC_W-1:0] tcol_s [TILE_OUT];
        for (genvar r = 0; r < TILE_IN; r++) begin : g_in
            assign col_s[r] = ACC_W'(m_r[r][c]);
        end
        winograd_at_kernel #(.ACC_W(ACC_W)) u_col_kernel (
            .x (col_s),
            .y (tcol_s)
        );
        for (genvar i = 0; i < TILE_OUT; i++) begin : g_out
            assign t_s[i][c] = tcol_s[i];
        end
    end

    // Row pass: Y[row_cnt, :] = (A^T * T[row_cnt, :]^T)^T.
    assign y_in_s = t_r[row_cnt_r];

    winograd_at_kernel #(.ACC_W(ACC_W)) u_row_kernel (
        .x (y_in_s),
        .y (y_row_s)
    );

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_CALC_T;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CALC_T: begin
                state_next_s = S_CALC_Y;
            end
            S_CALC_Y: begin
                if (row_cnt_r == 2'd3) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_CALC_Y;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register, registered handshake outputs and the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            row_cnt_r   <= 2'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int r = 0; r < TILE_IN; r++) begin
                for (int c = 0; c < TILE_IN; c++) begin
                    m_r[r][c] <= '0;
                end
            end
            for (int i = 0; i < TILE_OUT; i++) begin
                for (int c = 0; c < TILE_IN; c++) begin
                    t_r[i][c] <= '0;
                end
                for (int j = 0; j < TILE_OUT; j++) begin
                    tile_out_r[i][j] <= '0;
                end
            end
`ifdef WINOGRAD_OT_SAT_EN
            sat_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == S_IDLE);
            out_valid_r <= (state_next_s == S_DONE);
            busy_r      <= (state_next_s != S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        m_r       <= tile_in;
                        row_cnt_r <= 2'd0;
`ifdef WINOGRAD_OT_SAT_EN
                        sat_r     <= 1'b0;
`endif
                    end
                end
                S_CALC_T: begin
                    t_r       <= t_s;
                    row_cnt_r <= 2'd0;
                end
                S_CALC_Y: begin
                    for (int j = 0; j < TILE_OUT; j++) begin
                        tile_out_r[row_cnt_r][j] <= conv_y(y_row_s[j]);
                    end
                    // Wraps 3 -> 0 on the last row.
                    row_cnt_r <= row_cnt_r + 2'd1;
`ifdef WINOGRAD_OT_SAT_EN
                    sat_r <= sat_r | sat_hit_s;
`endif
                end
                S_DONE: begin
                    row_cnt_r <= 2'd0;
                end
                default: begin
                    row_cnt_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_winograd_output_transform.sv
// -----------------------------------------------------------------------------
// tb_winograd_output_transform
// Directed bench for winograd_output_transform (IN_W=32, OUT_W=16).
// Expected values are hand-derived constants plus an independent integer
// reference of A^T*M*A computed as a plain triple product.
// Honours WINOGRAD_OT_SAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_winograd_output_transform;

    typedef logic signed [31:0] mt_t [6][6];

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [31:0]  tile_in [6][6];
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  tile_out [4][4];
    logic                busy;
`ifdef WINOGRAD_OT_SAT_EN
    logic                sat_flag;
`endif

    int n_vec = 0;
    int n_err = 0;

    int AT [4][6] = '{
        '{1, 1,  1, 1,  1, 0},
        '{0, 1, -1, 2, -2, 0},
        '{0, 1,  1, 4,  4, 0},
        '{0, 1, -1, 8, -8, 1}
    };

    winograd_output_transform #(.IN_W(32), .OUT_W(16), .ACC_W(42)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tile_in   (tile_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tile_out  (tile_out),
`ifdef WINOGRAD_OT_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] ref_y(input mt_t m, input int i, input int j);
        logic signed [63:0] acc;
        acc = 64'sd0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                acc += longint'(AT[i][r]) * longint'(m[r][c]) * longint'(AT[j][c]);
            end
        end
`ifdef WINOGRAD_OT_SAT_EN
        if (acc > 64'sd32767) acc = 64'sd32767;
        if (acc < -64'sd32768) acc = -64'sd32768;
`endif
        return {{48{acc[15]}}, acc[15:0]};
    endfunction

    task automatic clr_tile(output mt_t m);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                m[r][c] = 32'sd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a tile, wait for acceptance, then measure edges until out_valid.
    task automatic start_tile(input string tag, input mt_t m);
        int w;
        int lat;
        w = 0;
        lat = 0;
        tile_in  = m;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            cyc();
            w++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        cyc();
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            cyc();
            lat++;
        end
        chk({tag, "_latency"}, lat, 5);
    endtask

    task automatic check_tile(input string tag, input mt_t m);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s_y%0d%0d", tag, i, j), tile_out[i][j], ref_y(m, i, j));
    endtask

    task automatic finish_tile(input string tag);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, out_valid, 0);
        chk({tag, "_busy_drop"}, busy, 0);
    endtask

    initial begin
        mt_t m_ones;
        mt_t m33;
        mt_t m55;
        mt_t mbig;
        mt_t mr;
        int  seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_tile(mr);
        tile_in   = mr;

        // Reset state.
        cyc();
        cyc();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y00", tile_out[0][0], 0);
        chk("rst_y33", tile_out[3][3], 0);
        rst = 1'b0;
        cyc();
        chk("post_rst_in_ready", in_ready, 1);

        // All-ones M: Y = r*r^T with r = [5,0,10,1].
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                m_ones[r][c] = 32'sd1;
        start_tile("ones", m_ones);
        chk("ones_busy", busy, 1);
        chk("ones_y00", tile_out[0][0], 25);
        chk("ones_y22", tile_out[2][2], 100);
        chk("ones_y03", tile_out[0][3], 5);
        chk("ones_y33", tile_out[3][3], 1);
        for (int j = 0; j < 4; j++)
            chk($sformatf("ones_y1%0d", j), tile_out[1][j], 0);
`ifdef WINOGRAD_OT_SAT_EN
        chk("ones_sat_flag", sat_flag, 0);
`endif
        check_tile("ones", m_ones);
        finish_tile("ones");

        // Single impulse at M[3][3]: v = [1,2,4,8].
        clr_tile(m33);
        m33[3][3] = 32'sd1;
        start_tile("m33", m33);
        chk("m33_y00", tile_out[0][0], 1);
        chk("m33_y12", tile_out[1][2], 8);
        chk("m33_y33", tile_out[3][3], 64);
        check_tile("m33", m33);
        finish_tile("m33");

        // Single impulse at M[5][5]: only Y[3][3] = 1.
        clr_tile(m55);
        m55[5][5] = 32'sd1;
        start_tile("m55", m55);
        chk("m55_y33", tile_out[3][3], 1);
        chk("m55_y00", tile_out[0][0], 0);
        chk("m55_y32", tile_out[3][2], 0);
        check_tile("m55", m55);
        finish_tile("m55");

        // M[4][4] = 1024, v = [1,-2,4,-8]: OUT_W boundary values.
        clr_tile(mbig);
        mbig[4][4] = 32'sd1024;
        start_tile("big", mbig);
        chk("big_y23", tile_out[2][3], -32768);
        chk("big_y13", tile_out[1][3], 16384);
`ifdef WINOGRAD_OT_SAT_EN
        chk("big_y33", tile_out[3][3], 32767);
        chk("big_sat_flag", sat_flag, 1);
`else
        chk("big_y33", tile_out[3][3], 0);
`endif
        check_tile("big", mbig);
        finish_tile("big");

        // Backpressure: hold out_ready low while offering a second tile.
        start_tile("bp", m_ones);
`ifdef WINOGRAD_OT_SAT_EN
        chk("bp_sat_cleared", sat_flag, 0);
`endif
        tile_in  = m33;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk($sformatf("bp_out_valid_%0d", k), out_valid, 1);
            chk($sformatf("bp_in_ready_%0d", k), in_ready, 0);
            chk($sformatf("bp_y00_%0d", k), tile_out[0][0], 25);
            chk($sformatf("bp_y22_%0d", k), tile_out[2][2], 100);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("bp_hs_out_valid", out_valid, 0);
        chk("bp_hs_in_ready", in_ready, 1);
        start_tile("bp2", m33);
        check_tile("bp2", m33);
        finish_tile("bp2");

        // Reset in S_CALC_Y with row_cnt = 2.
        tile_in  = m_ones;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (tile_out[i][j] !== 16'sd0) seen++;
        chk("mid_rst_tile_zero", seen, 0);
        rst = 1'b0;
        cyc();
        chk("mid_post_in_ready", in_ready, 1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (out_valid) seen++;
        end
        chk("mid_no_out_valid", seen, 0);
        start_tile("after_rst", m55);
        check_tile("after_rst", m55);
        finish_tile("after_rst");

        // Random signed tiles, |M| <= 90 so Y fits 16 bits (max gain 361).
        for (int t = 0; t < 20; t++) begin
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++)
                    mr[r][c] = int'($urandom_range(180, 0)) - 90;
            repeat ($urandom_range(3, 0)) cyc();
            start_tile($sformatf("rnd%0d", t), mr);
            repeat ($urandom_range(3, 0)) cyc();
            check_tile($sformatf("rnd%0d", t), mr);
            finish_tile($sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
